// File: rtl/mem_bus_arbiter_if.sv
// Shared memory-bus bundle between the two requesting masters, the arbiter and the
// memory map decoder. The arbiter takes the slave view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   m0_req;
    logic                   m0_we;
    logic [ADDR_LENGTH-1:0] m0_addr;
    logic [DATA_LENGTH-1:0] m0_wdata;
    logic                   m0_gnt;
    logic                   m0_ack;
    logic [DATA_LENGTH-1:0] m0_rdata;

    logic                   m1_req;
    logic                   m1_we;
    logic [ADDR_LENGTH-1:0] m1_addr;
    logic [DATA_LENGTH-1:0] m1_wdata;
    logic                   m1_gnt;
    logic                   m1_ack;
    logic [DATA_LENGTH-1:0] m1_rdata;

    logic                   MemRead;
    logic                   MemWrite;
    logic [ADDR_LENGTH-1:0] AddrOut;
    logic [DATA_LENGTH-1:0] DataOut;
    logic [DATA_LENGTH-1:0] DataIn;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  DataIn,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output MemRead, MemWrite, AddrOut, DataOut
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output DataIn,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  MemRead, MemWrite, AddrOut, DataOut
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory-mapped bus: latches the winning
// request, issues one strobe cycle, waits RD_LATENCY cycles for reads, then acks.
module mem_bus_arbiter #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int RD_LATENCY  = 1
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LP_WAIT_LOAD = 4'(RD_LATENCY - 1);

    state_t                 r_state, w_next;
    logic                   r_winner, r_we, r_last_gnt;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic [DATA_LENGTH-1:0] r_wdata;
    logic [3:0]             r_cnt;

    logic                   w_any_req, w_win;
    logic                   w_sel_id, w_sel_we;
    logic [ADDR_LENGTH-1:0] w_sel_addr;
    logic [DATA_LENGTH-1:0] w_sel_wdata;

    logic                   r_m0_gnt, r_m1_gnt, r_m0_ack, r_m1_ack;
    logic                   r_mem_read, r_mem_write;
    logic [ADDR_LENGTH-1:0] r_addr_out;
    logic [DATA_LENGTH-1:0] r_data_out, r_m0_rdata, r_m1_rdata;

    logic                   w_m0_gnt, w_m1_gnt, w_m0_ack, w_m1_ack;
    logic                   w_mem_read, w_mem_write;
    logic [ADDR_LENGTH-1:0] w_addr_out;
    logic [DATA_LENGTH-1:0] w_data_out;

    // In IDLE the outputs for the upcoming ACCESS come straight from the winning
    // request, since the latched copy only becomes valid at the same edge.
    always_comb begin
        w_any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) w_win = ~r_last_gnt;
        else                          w_win = bus.m1_req;
        if (r_state == S_IDLE) begin
            w_sel_id    = w_win;
            w_sel_we    = w_win ? bus.m1_we    : bus.m0_we;
            w_sel_addr  = w_win ? bus.m1_addr  : bus.m0_addr;
            w_sel_wdata = w_win ? bus.m1_wdata : bus.m0_wdata;
        end else begin
            w_sel_id    = r_winner;
            w_sel_we    = r_we;
            w_sel_addr  = r_addr;
            w_sel_wdata = r_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = r_we ? S_DONE : S_WAIT;
            S_WAIT:   if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_m0_gnt    = 1'b0;
        w_m1_gnt    = 1'b0;
        w_m0_ack    = 1'b0;
        w_m1_ack    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_addr_out  = '0;
        w_data_out  = '0;
        if (w_next != S_IDLE) begin
            w_m0_gnt = ~w_sel_id;
            w_m1_gnt = w_sel_id;
        end
        case (w_next)
            S_ACCESS: begin
                w_mem_read  = ~w_sel_we;
                w_mem_write = w_sel_we;
                w_addr_out  = w_sel_addr;
                w_data_out  = w_sel_wdata;
            end
            S_WAIT: begin
                w_addr_out = w_sel_addr;
                w_data_out = w_sel_wdata;
            end
            S_DONE: begin
                w_m0_ack = ~w_sel_id;
                w_m1_ack = w_sel_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_winner    <= 1'b0;
            r_we        <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr_out  <= '0;
            r_data_out  <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_state     <= w_next;
            r_m0_gnt    <= w_m0_gnt;
            r_m1_gnt    <= w_m1_gnt;
            r_m0_ack    <= w_m0_ack;
            r_m1_ack    <= w_m1_ack;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_addr_out  <= w_addr_out;
            r_data_out  <= w_data_out;
            if (r_state == S_IDLE && w_any_req) begin
                r_winner <= w_sel_id;
                r_we     <= w_sel_we;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
            end
            if (r_state == S_ACCESS && !r_we) r_cnt <= LP_WAIT_LOAD;
            if (r_state == S_WAIT) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (r_winner) begin
                    r_m1_rdata <= bus.DataIn;
                end else begin
                    r_m0_rdata <= bus.DataIn;
                end
            end
            if (r_state == S_DONE) r_last_gnt <= r_winner;
        end
    end

    assign bus.m0_gnt   = r_m0_gnt;
    assign bus.m1_gnt   = r_m1_gnt;
    assign bus.m0_ack   = r_m0_ack;
    assign bus.m1_ack   = r_m1_ack;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.MemRead  = r_mem_read;
    assign bus.MemWrite = r_mem_write;
    assign bus.AddrOut  = r_addr_out;
    assign bus.DataOut  = r_data_out;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: four instances with RD_LATENCY 1, 3, 4, 15 sharing clk/rst;
// acks are matched against a per-instance queue of expected (master, cycle, rdata).
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    logic din_auto = 1'b1;

    logic [3:0]  m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr [4];
    logic [31:0] m1_addr [4];
    logic [31:0] m0_wdata [4];
    logic [31:0] m1_wdata [4];
    logic [31:0] din [4];

    logic [3:0]  m0_gnt, m1_gnt, m0_ack, m1_ack, mrd, mwr;
    logic [31:0] m0_rdata [4];
    logic [31:0] m1_rdata [4];
    logic [31:0] aout [4];
    logic [31:0] dout [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 15;
        mem_bus_arbiter_if #(.ADDR_LENGTH(32), .DATA_LENGTH(32)) bif ();
        mem_bus_arbiter #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .RD_LATENCY(LAT)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bif)
        );
        assign bif.m0_req   = m0_req[g];
        assign bif.m1_req   = m1_req[g];
        assign bif.m0_we    = m0_we[g];
        assign bif.m1_we    = m1_we[g];
        assign bif.m0_addr  = m0_addr[g];
        assign bif.m1_addr  = m1_addr[g];
        assign bif.m0_wdata = m0_wdata[g];
        assign bif.m1_wdata = m1_wdata[g];
        assign bif.DataIn   = din[g];
        assign m0_gnt[g]    = bif.m0_gnt;
        assign m1_gnt[g]    = bif.m1_gnt;
        assign m0_ack[g]    = bif.m0_ack;
        assign m1_ack[g]    = bif.m1_ack;
        assign mrd[g]       = bif.MemRead;
        assign mwr[g]       = bif.MemWrite;
        assign m0_rdata[g]  = bif.m0_rdata;
        assign m1_rdata[g]  = bif.m1_rdata;
        assign aout[g]      = bif.AddrOut;
        assign dout[g]      = bif.DataOut;
    end

    typedef struct {
        int          m;
        int          cyc;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb [4][$];
    logic [31:0] mdl [4][2];

    function automatic int lat(int d);
        case (d)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] rd_val(int c);
        return {16'hC0DE, 16'(c)};
    endfunction

    function automatic void push(int d, int m, int ack_cyc, logic [31:0] rd);
        exp_t e;
        e.m   = m;
        e.cyc = ack_cyc;
        e.rd  = rd;
        sb[d].push_back(e);
        mdl[d][m] = rd;
    endfunction

    // DataIn carries the current cycle number so a read sampled one cycle early or late shows.
    task automatic tick();
        @(posedge clk);
        #1;
        if (din_auto) for (int d = 0; d < 4; d++) din[d] = rd_val(cyc);
    endtask

    task automatic clear_inputs();
        m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0;
        for (int d = 0; d < 4; d++) begin
            m0_addr[d] = '0; m1_addr[d] = '0;
            m0_wdata[d] = '0; m1_wdata[d] = '0;
            din[d] = '0;
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 4; d++) begin
            sb[d].delete();
            mdl[d][0] = '0;
            mdl[d][1] = '0;
        end
    endtask

    task automatic scoreboard_monitor();
        exp_t        e;
        logic        ack;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 4; d++) begin
                    if (m0_gnt[d] || m1_gnt[d]) begin
                        checks++;
                        if (m0_gnt[d] && m1_gnt[d])
                            $display("FAIL gnt_exclusive dut%0d cyc %0d: got both gnt high, required one", d, cyc);
                        else passes++;
                    end
                    for (int m = 0; m < 2; m++) begin
                        ack = (m == 0) ? m0_ack[d] : m1_ack[d];
                        rd  = (m == 0) ? m0_rdata[d] : m1_rdata[d];
                        if (ack) begin
                            checks++;
                            if (sb[d].size() == 0) begin
                                $display("FAIL unexpected_ack dut%0d m%0d cyc %0d: got ack, required none", d, m, cyc);
                            end else begin
                                e = sb[d].pop_front();
                                if (e.m != m || e.cyc != cyc)
                                    $display("FAIL ack_order_timing dut%0d: got m%0d at cyc %0d, required m%0d at cyc %0d",
                                             d, m, cyc, e.m, e.cyc);
                                else passes++;
                                checks++;
                                if (rd !== e.rd)
                                    $display("FAIL ack_rdata dut%0d m%0d cyc %0d: got %h, required %h", d, m, cyc, rd, e.rd);
                                else passes++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        clear_model();
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({m0_gnt[d], m1_gnt[d], m0_ack[d], m1_ack[d], mrd[d], mwr[d]} !== 6'b0)
                $display("FAIL reset_ctrl dut%0d: got %b, required 000000", d,
                         {m0_gnt[d], m1_gnt[d], m0_ack[d], m1_ack[d], mrd[d], mwr[d]});
            else passes++;
            checks++;
            if (aout[d] !== 32'h0 || dout[d] !== 32'h0)
                $display("FAIL reset_bus dut%0d: got addr %h data %h, required 0", d, aout[d], dout[d]);
            else passes++;
            checks++;
            if (m0_rdata[d] !== 32'h0 || m1_rdata[d] !== 32'h0)
                $display("FAIL reset_rdata dut%0d: got %h/%h, required 0", d, m0_rdata[d], m1_rdata[d]);
            else passes++;
        end
    endtask

    task automatic test_single_read();
        int c;
        din_auto = 1'b0;
        din[0] = 32'hDEAD_BEEF;
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h1001_0000;
        c = cyc;
        push(0, 0, c + 3, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (!(mrd[0] === 1'b1 && mwr[0] === 1'b0 && aout[0] === 32'h1001_0000 && m0_gnt[0] === 1'b1 && m1_gnt[0] === 1'b0))
            $display("FAIL read_access: got rd %b wr %b addr %h gnt %b%b, required 1 0 10010000 10",
                     mrd[0], mwr[0], aout[0], m0_gnt[0], m1_gnt[0]);
        else passes++;
        tick();
        checks++;
        if (mrd[0] !== 1'b0 || aout[0] !== 32'h1001_0000)
            $display("FAIL read_wait: got rd %b addr %h, required 0 10010000", mrd[0], aout[0]);
        else passes++;
        tick();
        checks++;
        if (m1_gnt[0] !== 1'b0 || m1_ack[0] !== 1'b0 || m1_rdata[0] !== mdl[0][1])
            $display("FAIL read_m1_untouched: got gnt %b ack %b rdata %h, required 0 0 %h",
                     m1_gnt[0], m1_ack[0], m1_rdata[0], mdl[0][1]);
        else passes++;
        m0_req[0] = 1'b0;
        tick();
        checks++;
        if (m0_gnt[0] !== 1'b0 || aout[0] !== 32'h0)
            $display("FAIL read_idle: got gnt %b addr %h, required 0 0", m0_gnt[0], aout[0]);
        else passes++;
        din_auto = 1'b1;
    endtask

    task automatic test_single_write();
        int c;
        m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h1001_0024; m1_wdata[0] = 32'h0000_00A5;
        c = cyc;
        push(0, 1, c + 2, mdl[0][1]);
        tick();
        checks++;
        if (!(mwr[0] === 1'b1 && mrd[0] === 1'b0 && aout[0] === 32'h1001_0024 && dout[0] === 32'hA5 && m1_gnt[0] === 1'b1))
            $display("FAIL write_access: got wr %b rd %b addr %h data %h gnt1 %b, required 1 0 10010024 000000a5 1",
                     mwr[0], mrd[0], aout[0], dout[0], m1_gnt[0]);
        else passes++;
        tick();
        checks++;
        if (m0_rdata[0] !== mdl[0][0])
            $display("FAIL write_m0_rdata: got %h, required %h", m0_rdata[0], mdl[0][0]);
        else passes++;
        m1_req[0] = 1'b0;
        tick();
        checks++;
        if (mwr[0] !== 1'b0 || m1_gnt[0] !== 1'b0 || dout[0] !== 32'h0)
            $display("FAIL write_idle: got wr %b gnt %b data %h, required 0 0 0", mwr[0], m1_gnt[0], dout[0]);
        else passes++;
    endtask

    task automatic test_tie_fairness();
        int c, k, p;
        logic eg0, eg1;
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h1000_0100;
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h1000_0200;
        c = cyc;
        for (int i = 0; i < 4; i++) push(0, i % 2, c + 4 * i + 3, rd_val(c + 4 * i + 2));
        for (int t = 1; t <= 16; t++) begin
            tick();
            k = (t - 1) / 4;
            p = (t - 1) % 4;
            eg0 = (p < 3) && (k % 2 == 0);
            eg1 = (p < 3) && (k % 2 == 1);
            checks++;
            if ({m0_gnt[0], m1_gnt[0]} !== {eg0, eg1})
                $display("FAIL tie_gnt t%0d: got %b%b, required %b%b", t, m0_gnt[0], m1_gnt[0], eg0, eg1);
            else passes++;
            if (p == 0) begin
                checks++;
                if (mrd[0] !== 1'b1 || aout[0] !== ((k % 2 == 1) ? 32'h1000_0200 : 32'h1000_0100))
                    $display("FAIL tie_access t%0d: got rd %b addr %h", t, mrd[0], aout[0]);
                else passes++;
            end
            if (t == 15) begin
                m0_req[0] = 1'b0;
                m1_req[0] = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, k, p;
        m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'h1001_0008; m0_wdata[0] = 32'h1000;
        c = cyc;
        for (int i = 0; i < 3; i++) push(0, 0, c + 3 * i + 2, mdl[0][0]);
        for (int t = 1; t <= 9; t++) begin
            tick();
            k = (t - 1) / 3;
            p = (t - 1) % 3;
            if (p == 0) begin
                checks++;
                if (mwr[0] !== 1'b1 || dout[0] !== 32'h1000 + 32'(k))
                    $display("FAIL b2b_write t%0d: got wr %b data %h, required 1 %h", t, mwr[0], dout[0], 32'h1000 + 32'(k));
                else passes++;
                m0_wdata[0] = 32'h1000 + 32'(k + 1);
            end
            if (t == 8) m0_req[0] = 1'b0;
            if (t == 9) begin
                checks++;
                if (m0_gnt[0] !== 1'b0 || mwr[0] !== 1'b0)
                    $display("FAIL b2b_idle: got gnt %b wr %b, required 0 0", m0_gnt[0], mwr[0]);
                else passes++;
            end
        end
    endtask

    task automatic test_input_instability();
        int c;
        m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'h2000_0040;
        c = cyc;
        push(1, 0, c + 5, rd_val(c + 4));
        tick();
        checks++;
        if (aout[1] !== 32'h2000_0040 || mrd[1] !== 1'b1)
            $display("FAIL instab_access: got addr %h rd %b, required 20000040 1", aout[1], mrd[1]);
        else passes++;
        m0_addr[1] = 32'h0;
        for (int t = 2; t <= 4; t++) begin
            tick();
            if (t == 2) begin
                m0_req[1] = 1'b0;
                m0_we[1]  = 1'b1;
            end
            checks++;
            if (aout[1] !== 32'h2000_0040 || mrd[1] !== 1'b0 || mwr[1] !== 1'b0)
                $display("FAIL instab_wait t%0d: got addr %h rd %b wr %b, required 20000040 0 0", t, aout[1], mrd[1], mwr[1]);
            else passes++;
        end
        tick();
        checks++;
        if (aout[1] !== 32'h0)
            $display("FAIL instab_done_addr: got %h, required 0", aout[1]);
        else passes++;
        for (int t = 6; t <= 7; t++) begin
            tick();
            checks++;
            if (m0_gnt[1] !== 1'b0 || mrd[1] !== 1'b0 || mwr[1] !== 1'b0)
                $display("FAIL instab_no_new t%0d: got gnt %b rd %b wr %b, required 0 0 0", t, m0_gnt[1], mrd[1], mwr[1]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_transfer();
        int c;
        m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'h3000_0000;
        tick();
        tick();
        rst = 1'b1;
        clear_model();
        tick();
        for (int t = 0; t < 2; t++) begin
            checks++;
            if ({m0_gnt[1], m1_gnt[1], m0_ack[1], m1_ack[1], mrd[1], mwr[1]} !== 6'b0 || aout[1] !== 32'h0 || m0_rdata[1] !== 32'h0)
                $display("FAIL midrst_outputs step%0d: got ctrl %b addr %h rdata %h, required 0", t,
                         {m0_gnt[1], m1_gnt[1], m0_ack[1], m1_ack[1], mrd[1], mwr[1]}, aout[1], m0_rdata[1]);
            else passes++;
            rst = 1'b0;
            m0_req[1] = 1'b0;
            tick();
        end
        m0_req[1] = 1'b1; m0_addr[1] = 32'h3000_0010;
        m1_req[1] = 1'b1; m1_we[1] = 1'b0; m1_addr[1] = 32'h3000_0020;
        c = cyc;
        push(1, 0, c + 5, rd_val(c + 4));
        tick();
        checks++;
        if (m0_gnt[1] !== 1'b1 || m1_gnt[1] !== 1'b0)
            $display("FAIL midrst_tie: got gnt %b%b, required 10", m0_gnt[1], m1_gnt[1]);
        else passes++;
        m1_req[1] = 1'b0;
        for (int t = 2; t <= 6; t++) begin
            tick();
            if (t == 5) m0_req[1] = 1'b0;
        end
    endtask

    task automatic test_latency_sweep();
        int d, l, c;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 0 : (i == 1) ? 2 : 3;
            l = lat(d);
            m1_req[d] = 1'b1; m1_we[d] = 1'b0; m1_addr[d] = 32'h1002_0000 + 32'(d * 4);
            c = cyc;
            push(d, 1, c + 2 + l, rd_val(c + 1 + l));
            for (int t = 1; t <= l + 3; t++) begin
                tick();
                checks++;
                if (mrd[d] !== (t == 1))
                    $display("FAIL lat_strobe dut%0d t%0d: got MemRead %b, required %b", d, t, mrd[d], (t == 1));
                else passes++;
                if (t == l + 2) m1_req[d] = 1'b0;
            end
        end
    endtask

    initial begin
        clear_inputs();
        clear_model();
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_single_read();
        test_single_write();
        test_reset();
        test_tie_fairness();
        test_back_to_back();
        test_input_instability();
        test_reset_mid_transfer();
        test_latency_sweep();
        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (sb[d].size() != 0)
                $display("FAIL missing_ack dut%0d: got %0d pending, required 0", d, sb[d].size());
            else passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
